// File: rtl/ipr1_pixstream_tx.sv
// IPR1 pixel-stream transmitter: an input FIFO feeds a raster FSM that inserts line/frame blanking.
// Optional test-pattern source is compiled in when IPR1_PIXTX_TESTPAT_EN is defined.
module ipr1_pixstream_tx #(
    parameter int WIDTH      = 512,
    parameter int HEIGHT     = 512,
    parameter int HBLANK     = 16,
    parameter int VBLANK     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] s_pixel,
    input  logic       s_valid,
`ifdef IPR1_PIXTX_TESTPAT_EN
    input  logic       testpat,
`endif
    output logic       s_ready,
    output logic [7:0] pixelout,
    output logic       frame_valid,
    output logic       data_valid,
    output logic [9:0] col_cnt,
    output logic [9:0] row_cnt,
    output logic       underrun,
    output logic       frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HBLANK = 2'd2;
    localparam logic [1:0] S_VBLANK = 2'd3;

    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [9:0]    COL_LAST = 10'(WIDTH - 1);
    localparam logic [9:0]    ROW_LAST = 10'(HEIGHT - 1);
    localparam logic [15:0]   HB_LAST  = 16'(HBLANK - 1);
    localparam logic [15:0]   VB_LAST  = 16'(VBLANK - 1);

    // ---------------- input FIFO ----------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_s_ready;
    logic [AW:0]   w_count_nxt;
    logic          w_wr;
    logic          w_rd;
    logic          w_empty;

    assign w_empty = (r_count == '0);
    assign w_wr    = s_valid & r_s_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // s_ready is registered from the next count so it already reflects this cycle's read/write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_s_ready <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count   <= w_count_nxt;
            r_s_ready <= (w_count_nxt != DEPTH_C);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= s_pixel;
    end

    // ---------------- raster FSM ----------------
    logic [1:0]  r_state;
    logic [9:0]  r_col;
    logic [9:0]  r_row;
    logic [15:0] r_bcnt;
    logic [7:0]  r_pixelout;
    logic        r_frame_valid;
    logic        r_data_valid;
    logic [9:0]  r_col_cnt;
    logic [9:0]  r_row_cnt;
    logic        r_underrun;
    logic        r_frame_done;

    logic        w_start;
    logic        w_tp;
    logic [7:0]  w_pix_src;
    logic        w_beat;
    logic        w_frame_start;

`ifdef IPR1_PIXTX_TESTPAT_EN
    logic       r_tp;
    logic [7:0] w_tp_pix;

    assign w_start   = enable & (testpat | ~w_empty);
    assign w_tp      = r_tp;
    assign w_tp_pix  = r_col[7:0] + r_row[7:0];
    assign w_pix_src = r_tp ? w_tp_pix : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              r_tp <= 1'b0;
        else if (w_frame_start) r_tp <= testpat;
    end
`else
    assign w_start   = enable & ~w_empty;
    assign w_tp      = 1'b0;
    assign w_pix_src = r_mem[r_rd_ptr];
`endif

    assign w_frame_start = w_start &
                           ((r_state == S_IDLE) | ((r_state == S_VBLANK) & (r_bcnt == VB_LAST)));
    assign w_beat        = (r_state == S_ACTIVE) & (w_tp | ~w_empty);
    assign w_rd          = (r_state == S_ACTIVE) & ~w_tp & ~w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_bcnt        <= '0;
            r_pixelout    <= '0;
            r_frame_valid <= 1'b0;
            r_data_valid  <= 1'b0;
            r_col_cnt     <= '0;
            r_row_cnt     <= '0;
            r_underrun    <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_underrun   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_frame_start) begin
                        r_state <= S_ACTIVE;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (w_beat) begin
                        r_pixelout    <= w_pix_src;
                        r_data_valid  <= 1'b1;
                        r_frame_valid <= 1'b1;
                        r_col_cnt     <= r_col;
                        r_row_cnt     <= r_row;
                        if (r_col == COL_LAST) begin
                            r_state <= S_HBLANK;
                            r_bcnt  <= '0;
                        end else begin
                            r_col <= r_col + 10'd1;
                        end
                    end else begin
                        r_underrun <= 1'b1;
                    end
                end
                S_HBLANK: begin
                    if (r_bcnt == HB_LAST) begin
                        r_bcnt <= '0;
                        if (r_row != ROW_LAST) begin
                            r_row   <= r_row + 10'd1;
                            r_col   <= '0;
                            r_state <= S_ACTIVE;
                        end else begin
                            r_state <= S_VBLANK;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + 16'd1;
                    end
                end
                default: begin
                    // VBLANK: the frame boundary is the only point where enable is re-examined.
                    r_frame_valid <= 1'b0;
                    if (r_bcnt == VB_LAST) begin
                        r_frame_done <= 1'b1;
                        r_bcnt       <= '0;
                        if (w_frame_start) begin
                            r_state <= S_ACTIVE;
                            r_col   <= '0;
                            r_row   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign s_ready     = r_s_ready;
    assign pixelout    = r_pixelout;
    assign frame_valid = r_frame_valid;
    assign data_valid  = r_data_valid;
    assign col_cnt     = r_col_cnt;
    assign row_cnt     = r_row_cnt;
    assign underrun    = r_underrun;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_ipr1_pixstream_tx.sv
// Scoreboard bench for ipr1_pixstream_tx: a 4x2 raster with a 16-deep FIFO plus a 4-deep FIFO copy.
// Test-pattern scenario is compiled only when IPR1_PIXTX_TESTPAT_EN is defined.
module tb_ipr1_pixstream_tx;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int HB = 2;
    localparam int VB = 3;

    typedef struct packed {
        logic [7:0] pix;
        logic [9:0] col;
        logic [9:0] row;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       a_enable, a_s_valid, a_s_ready, a_frame_valid, a_data_valid, a_underrun, a_frame_done;
    logic [7:0] a_s_pixel, a_pixelout;
    logic [9:0] a_col_cnt, a_row_cnt;
    logic       b_enable, b_s_valid, b_s_ready, b_frame_valid, b_data_valid, b_underrun, b_frame_done;
    logic [7:0] b_s_pixel, b_pixelout;
    logic [9:0] b_col_cnt, b_row_cnt;
`ifdef IPR1_PIXTX_TESTPAT_EN
    logic       a_testpat, b_testpat;
`endif

    int    checks   = 0;
    int    failures = 0;
    beat_t sb[$];

    ipr1_pixstream_tx #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB), .FIFO_DEPTH(16)) u_dut_a (
        .clk(clk), .reset(reset), .enable(a_enable), .s_pixel(a_s_pixel), .s_valid(a_s_valid),
`ifdef IPR1_PIXTX_TESTPAT_EN
        .testpat(a_testpat),
`endif
        .s_ready(a_s_ready), .pixelout(a_pixelout), .frame_valid(a_frame_valid),
        .data_valid(a_data_valid), .col_cnt(a_col_cnt), .row_cnt(a_row_cnt),
        .underrun(a_underrun), .frame_done(a_frame_done)
    );

    ipr1_pixstream_tx #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .reset(reset), .enable(b_enable), .s_pixel(b_s_pixel), .s_valid(b_s_valid),
`ifdef IPR1_PIXTX_TESTPAT_EN
        .testpat(b_testpat),
`endif
        .s_ready(b_s_ready), .pixelout(b_pixelout), .frame_valid(b_frame_valid),
        .data_valid(b_data_valid), .col_cnt(b_col_cnt), .row_cnt(b_row_cnt),
        .underrun(b_underrun), .frame_done(b_frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] v);
        a_s_valid = 1'b1;
        a_s_pixel = v;
        step();
        a_s_valid = 1'b0;
    endtask

    function automatic beat_t got_a();
        return '{pix: a_pixelout, col: a_col_cnt, row: a_row_cnt};
    endfunction

    function automatic beat_t mk(input int pix, input int idx);
        return '{pix: 8'(pix), col: 10'(idx % W), row: 10'(idx / W)};
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        a_enable  = 1'b0; a_s_valid = 1'b0; a_s_pixel = '0;
        b_enable  = 1'b0; b_s_valid = 1'b0; b_s_pixel = '0;
`ifdef IPR1_PIXTX_TESTPAT_EN
        a_testpat = 1'b0; b_testpat = 1'b0;
`endif
        repeat (3) step();
        checks++;
        if ({a_s_ready, a_pixelout, a_frame_valid, a_data_valid, a_col_cnt, a_row_cnt,
             a_underrun, a_frame_done} !== '0) begin
            failures++;
            $display("FAIL reset_a: outputs %h, expected all zero", {a_s_ready, a_pixelout,
                     a_frame_valid, a_data_valid, a_col_cnt, a_row_cnt, a_underrun, a_frame_done});
        end
        checks++;
        if ({b_s_ready, b_pixelout, b_frame_valid, b_data_valid, b_col_cnt, b_row_cnt,
             b_underrun, b_frame_done} !== '0) begin
            failures++;
            $display("FAIL reset_b: outputs %h, expected all zero", {b_s_ready, b_pixelout,
                     b_frame_valid, b_data_valid, b_col_cnt, b_row_cnt, b_underrun, b_frame_done});
        end
        reset = 1'b0;
        step();
        checks++;
        if (a_s_ready !== 1'b1 || b_s_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: a=%b b=%b, expected 1 1", a_s_ready, b_s_ready);
        end
    endtask

    task automatic test_frame();
        beat_t exp;
        int    fv_cyc = 0, gap_cyc = 0, low_after = 0, total = 0, under = 0;
        bit    started = 0, done = 0;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            push_a(8'(8'h10 + i));
            sb.push_back(mk(8'h10 + i, i));
        end
        a_enable = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            step();
            if (a_underrun) under++;
            if (a_frame_valid && !started) begin
                started = 1;
                checks++;
                if (a_data_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL frame_valid_rise: data_valid=%b, expected 1", a_data_valid);
                end
            end
            if (started) total++;
            if (a_frame_valid) fv_cyc++;
            if (a_frame_valid && !a_data_valid) gap_cyc++;
            if (started && !a_frame_valid) low_after++;
            if (a_data_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL frame_beat: unexpected pixel %h", a_pixelout);
                end else begin
                    exp = sb.pop_front();
                    if (got_a() !== exp) begin
                        failures++;
                        $display("FAIL frame_beat: got pix=%h col=%0d row=%0d, expected pix=%h col=%0d row=%0d",
                                 a_pixelout, a_col_cnt, a_row_cnt, exp.pix, exp.col, exp.row);
                    end
                end
            end
            if (a_frame_done) begin
                done = 1;
                checks++;
                if (low_after !== VB) begin
                    failures++;
                    $display("FAIL frame_done_pos: on low cycle %0d, expected %0d", low_after, VB);
                end
            end
        end
        checks++;
        if (!done) begin failures++; $display("FAIL frame_timeout: no frame_done, expected one"); end
        checks++;
        if (fv_cyc !== H * (W + HB)) begin
            failures++;
            $display("FAIL frame_valid_len: %0d cycles, expected %0d", fv_cyc, H * (W + HB));
        end
        checks++;
        if (gap_cyc !== H * HB) begin
            failures++;
            $display("FAIL hblank_gaps: %0d cycles, expected %0d", gap_cyc, H * HB);
        end
        checks++;
        if (total !== H * (W + HB) + VB) begin
            failures++;
            $display("FAIL frame_len: %0d cycles, expected %0d", total, H * (W + HB) + VB);
        end
        checks++;
        if (under !== 0 || sb.size() !== 0) begin
            failures++;
            $display("FAIL frame_clean: underruns=%0d leftover=%0d, expected 0 0", under, sb.size());
        end
        step();
        checks++;
        if (a_frame_done !== 1'b0) begin
            failures++;
            $display("FAIL frame_done_width: frame_done=%b, expected 0", a_frame_done);
        end
        a_enable = 1'b0;
    endtask

    task automatic test_underrun();
        beat_t exp;
        int    beats = 0, gap = 0, under = 0, src = 3;
        bit    done = 0;
        sb.delete();
        for (int i = 0; i < 8; i++) sb.push_back(mk(8'h20 + i, i));
        for (int i = 0; i < 3; i++) push_a(8'(8'h20 + i));
        a_enable = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            // The source stalls after the first three pixels and resumes once the gap has elapsed.
            if (gap >= 4 && src < 8) begin
                a_s_valid = 1'b1;
                a_s_pixel = 8'(8'h20 + src);
            end
            step();
            if (a_s_valid) src++;
            a_s_valid = 1'b0;
            if (beats == 3) gap++;
            if (a_underrun) begin
                under++;
                checks++;
                if (a_data_valid !== 1'b0 || a_col_cnt !== 10'd2 || a_row_cnt !== 10'd0) begin
                    failures++;
                    $display("FAIL underrun_hold: dv=%b col=%0d row=%0d, expected 0 2 0",
                             a_data_valid, a_col_cnt, a_row_cnt);
                end
            end
            if (a_data_valid) begin
                beats++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL underrun_beat: unexpected pixel %h", a_pixelout);
                end else begin
                    exp = sb.pop_front();
                    if (got_a() !== exp) begin
                        failures++;
                        $display("FAIL underrun_beat: got pix=%h col=%0d row=%0d, expected pix=%h col=%0d row=%0d",
                                 a_pixelout, a_col_cnt, a_row_cnt, exp.pix, exp.col, exp.row);
                    end
                end
            end
            if (a_frame_done) done = 1;
        end
        checks++;
        if (under !== 5) begin
            failures++;
            $display("FAIL underrun_count: %0d cycles, expected 5", under);
        end
        checks++;
        if (!done || sb.size() !== 0) begin
            failures++;
            $display("FAIL underrun_frame: done=%b leftover=%0d, expected 1 0", done, sb.size());
        end
        a_enable = 1'b0;
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        bit got = 0;
        for (int i = 0; i < 8; i++) begin
            b_s_valid = 1'b1;
            b_s_pixel = 8'(8'h30 + i);
            if (b_s_ready) acc++;
            step();
        end
        b_s_valid = 1'b0;
        checks++;
        if (acc !== 4 || b_s_ready !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full: accepted=%0d ready=%b, expected 4 0", acc, b_s_ready);
        end
        b_enable = 1'b1;
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            step();
            checks++;
            if (b_data_valid) begin
                got = 1;
                if (b_s_ready !== 1'b1 || b_pixelout !== 8'h30 || b_col_cnt !== 10'd0 || b_row_cnt !== 10'd0) begin
                    failures++;
                    $display("FAIL fifo_drain: ready=%b pix=%h col=%0d row=%0d, expected 1 30 0 0",
                             b_s_ready, b_pixelout, b_col_cnt, b_row_cnt);
                end
            end else if (b_s_ready !== 1'b0) begin
                failures++;
                $display("FAIL fifo_full_hold: ready=%b before first read, expected 0", b_s_ready);
            end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL fifo_drain_timeout: no beat, expected one"); end
        b_enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        beat_t exp;
        bit    hit = 0, done = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            push_a(8'(8'h40 + i));
            sb.push_back(mk(8'h40 + i, i));
        end
        a_enable = 1'b1;
        for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
            step();
            if (a_data_valid) begin
                checks++;
                exp = sb.pop_front();
                if (got_a() !== exp) begin
                    failures++;
                    $display("FAIL pre_reset_beat: got pix=%h col=%0d row=%0d, expected pix=%h col=%0d row=%0d",
                             a_pixelout, a_col_cnt, a_row_cnt, exp.pix, exp.col, exp.row);
                end
                if (a_row_cnt == 10'd1 && a_col_cnt == 10'd2) hit = 1;
            end
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL reset_mid_reach: row1 col2 not reached, expected reached"); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a_s_ready, a_pixelout, a_frame_valid, a_data_valid, a_col_cnt, a_row_cnt,
             a_underrun, a_frame_done} !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear: outputs %h, expected all zero", {a_s_ready, a_pixelout,
                     a_frame_valid, a_data_valid, a_col_cnt, a_row_cnt, a_underrun, a_frame_done});
        end
        step();
        reset = 1'b0;
        sb.delete();
        repeat (8) begin
            step();
            checks++;
            if (a_frame_valid || a_data_valid || a_underrun) begin
                failures++;
                $display("FAIL reset_mid_flush: fv=%b dv=%b ur=%b with empty FIFO, expected 0 0 0",
                         a_frame_valid, a_data_valid, a_underrun);
            end
        end
        a_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_a(8'(8'h50 + i));
            sb.push_back(mk(8'h50 + i, i));
        end
        a_enable = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            step();
            if (a_data_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL post_reset_beat: unexpected pixel %h", a_pixelout);
                end else begin
                    exp = sb.pop_front();
                    if (got_a() !== exp) begin
                        failures++;
                        $display("FAIL post_reset_beat: got pix=%h col=%0d row=%0d, expected pix=%h col=%0d row=%0d",
                                 a_pixelout, a_col_cnt, a_row_cnt, exp.pix, exp.col, exp.row);
                    end
                end
            end
            if (a_frame_done) done = 1;
        end
        checks++;
        if (!done || sb.size() !== 0) begin
            failures++;
            $display("FAIL post_reset_frame: done=%b leftover=%0d, expected 1 0", done, sb.size());
        end
        a_enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        beat_t exp;
        bit    done = 0;
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            push_a(8'(8'h60 + i));
            if (i < 8) sb.push_back(mk(8'h60 + i, i));
        end
        a_enable = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            step();
            if (a_data_valid) begin
                a_enable = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL enable_drop_beat: unexpected pixel %h", a_pixelout);
                end else begin
                    exp = sb.pop_front();
                    if (got_a() !== exp) begin
                        failures++;
                        $display("FAIL enable_drop_beat: got pix=%h col=%0d row=%0d, expected pix=%h col=%0d row=%0d",
                                 a_pixelout, a_col_cnt, a_row_cnt, exp.pix, exp.col, exp.row);
                    end
                end
            end
            if (a_frame_done) done = 1;
        end
        checks++;
        if (!done || sb.size() !== 0) begin
            failures++;
            $display("FAIL enable_drop_frame: done=%b leftover=%0d, expected 1 0", done, sb.size());
        end
        repeat (20) begin
            step();
            checks++;
            if (a_frame_valid || a_data_valid) begin
                failures++;
                $display("FAIL enable_drop_idle: fv=%b dv=%b after frame, expected 0 0",
                         a_frame_valid, a_data_valid);
            end
        end
    endtask

`ifdef IPR1_PIXTX_TESTPAT_EN
    task automatic test_testpat();
        beat_t exp;
        int    under = 0;
        bit    done = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        sb.delete();
        for (int i = 0; i < 8; i++) sb.push_back(mk((i % W) + (i / W), i));
        a_testpat = 1'b1;
        a_enable  = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            step();
            if (a_underrun) under++;
            if (a_data_valid) begin
                a_testpat = 1'b0;
                a_enable  = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL testpat_beat: unexpected pixel %h", a_pixelout);
                end else begin
                    exp = sb.pop_front();
                    if (got_a() !== exp) begin
                        failures++;
                        $display("FAIL testpat_beat: got pix=%h col=%0d row=%0d, expected pix=%h col=%0d row=%0d",
                                 a_pixelout, a_col_cnt, a_row_cnt, exp.pix, exp.col, exp.row);
                    end
                end
            end
            if (a_frame_done) done = 1;
        end
        checks++;
        if (!done || under !== 0 || sb.size() !== 0) begin
            failures++;
            $display("FAIL testpat_frame: done=%b underruns=%0d leftover=%0d, expected 1 0 0",
                     done, under, sb.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_underrun();
        test_fifo_full();
        test_reset_mid();
        test_enable_drop();
`ifdef IPR1_PIXTX_TESTPAT_EN
        test_testpat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ipr1_pixstream_tx.md
# ipr1_pixstream_tx

Pixel-stream transmitter for the IPR1 image-processing chain. It accepts 8-bit pixels from a memory or DMA side over a valid/ready handshake and buffers them in a small FIFO. It then emits them as a raster-ordered stream on the `frame_valid` / `data_valid` / pixel interface that the IPR1 motion-trigger and other pixel consumers receive. Blanking is inserted between lines and frames, and per-pixel column/row coordinates are provided.

## Interface
- `WIDTH`, 512, active pixels per line (2..1024)
- `HEIGHT`, 512, lines per frame (1..1024)
- `HBLANK`, 16, idle cycles after each line while `frame_valid`=1 (≥1)
- `VBLANK`, 8, cycles with `frame_valid`=0 after the last line (≥1)
- `FIFO_DEPTH`, 16, input FIFO entries (power of two, ≥4)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  permits starting a new frame
- `s_pixel`  in  8  input pixel
- `s_valid`  in  1  `s_pixel` valid
- `s_ready`  out  1  FIFO can accept a pixel
- `pixelout`  out  8  output pixel
- `frame_valid`  out  1  high from the first pixel of line 0 through the HBLANK of the last line
- `data_valid`  out  1  `pixelout` holds a valid pixel
- `col_cnt`  out  10  column of the current `pixelout` pixel
- `row_cnt`  out  10  row of the current `pixelout` pixel
- `underrun`  out  1  one-cycle pulse for each ACTIVE cycle stalled on an empty FIFO
- `frame_done`  out  1  one-cycle pulse on the last VBLANK cycle

## Operation
- FIFO
  - A write occurs on `s_valid` & `s_ready`.
  - `s_ready` = !full, driven from the registered count.
  - A read occurs only in ACTIVE when not empty.
  - There is no fall-through: a pixel written into an empty FIFO becomes readable the next cycle.
  - Simultaneous read and write keeps the count unchanged.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
  - IDLE → ACTIVE when `enable`=1 and the FIFO is not empty. Column and row reset to 0.
  - ACTIVE: each FIFO read produces one output pixel with `data_valid`=1, then the column is incremented.
    - When the FIFO is empty, `data_valid`=0 and `underrun`=1. Counters hold and the state stays ACTIVE.
    - After pixel WIDTH-1 the FSM goes to HBLANK.
  - HBLANK: `frame_valid`=1, `data_valid`=0 for HBLANK cycles.
    - If row < HEIGHT-1: row is incremented, column resets to 0, then → ACTIVE.
    - Otherwise → VBLANK.
  - VBLANK: `frame_valid`=0 for VBLANK cycles. `frame_done` pulses on the last of these cycles.
    - Next state is ACTIVE (row 0) if `enable`=1 and the FIFO is not empty; otherwise IDLE.
- Deasserting `enable` mid-frame has no effect until the frame boundary. The current frame always completes.
- `col_cnt` and `row_cnt` are updated only on output beats and hold their values otherwise.

## Timing
- All outputs are registered.
- Reset values:
  - `s_ready`=0 while reset is high, then 1 on the first cycle after release (FIFO empty).
  - `pixelout`=0, `frame_valid`=0, `data_valid`=0, `col_cnt`=0, `row_cnt`=0, `underrun`=0, `frame_done`=0.
- Reset mid-frame: all outputs are cleared immediately (asynchronously), the FIFO is flushed and the FSM returns to IDLE.
- Latency: a pixel accepted at edge t appears on `pixelout` no earlier than edge t+2.
- `frame_valid` rises in the same cycle as the first `data_valid` of row 0. It falls on the first VBLANK cycle.
- With a continuously non-empty FIFO, each frame lasts HEIGHT·(WIDTH+HBLANK)+VBLANK cycles.
- `frame_done` and the next frame's first beat never overlap. The earliest next beat is the cycle after `frame_done`.

## Configuration
- `IPR1_PIXTX_TESTPAT_EN`
  - Defined: adds input port `testpat` (1 bit), sampled at frame start.
    - When set, the frame is generated without reading the FIFO: `pixelout` = (col+row)[7:0], never underruns, and the IDLE start condition needs only `enable`=1.
    - FIFO writes continue normally.
  - Undefined: no `testpat` port. All pixels come from the FIFO.

## Test plan
- Params WIDTH=4, HEIGHT=2, HBLANK=2, VBLANK=3; preload 8 pixels 0x10..0x17, then `enable`=1 → two lines of 4 `data_valid` beats (0x10..0x13, 0x14..0x17) with cols 0..3 and rows 0,1; 2-cycle gaps; `frame_valid` high for 12 cycles; `frame_done` pulses 3 cycles after `frame_valid` falls.
- Same params, 3 pixels available, then a 5-cycle source gap → 3 beats, then 5 cycles of `underrun`=1 with `data_valid`=0 and `col_cnt` held at 2, then resumption at col 3.
- FIFO_DEPTH=4, no reads (`enable`=0), `s_valid`=1 → exactly 4 writes accepted, then `s_ready`=0; a read from ACTIVE restores `s_ready`=1 on the next cycle.
- `reset` asserted during row 1, col 2 → all outputs 0 in the same cycle, FIFO empty; after release, the next frame starts at col 0, row 0 only after new pixels are written.
- `enable` dropped during row 0 → the frame completes both rows and the FSM returns to IDLE after VBLANK; no second frame starts.
- With `IPR1_PIXTX_TESTPAT_EN` and `testpat`=1, empty FIFO → the frame emits (col+row) values 0,1,2,3 and 1,2,3,4 with no `underrun`.
